// File: rtl/logic_pkg.sv
// Shared opcodes, FSM state encoding and helper functions for the logic op sequencer.
// Parity flag generation is enabled by defining LOGIC_PARITY_FLAG_EN.
package logic_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_NOT  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_EXEC   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Unary ops take only the A beat.
  function automatic logic is_unary(input logic [2:0] op);
    return (op == OP_NOT) || (op == OP_PASS);
  endfunction

  function automatic logic parity_even(input logic [7:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/and8.sv
// 8-bit bitwise AND gate of the logic gate array.
module and8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = a & b;
endmodule

// File: rtl/logic8_select.sv
// Combinational gate array plus result mux; output is a pure function of a, b and op.
module logic8_select
  import logic_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [2:0] op,
  output logic [7:0] y
);

  logic [7:0] and_s, or_s, xor_s, nor_s, nand_s, xnor_s, not_s;

  and8  u_and  (.a(a), .b(b), .y(and_s));
  or8   u_or   (.a(a), .b(b), .y(or_s));
  xor8  u_xor  (.a(a), .b(b), .y(xor_s));
  nor8  u_nor  (.a(a), .b(b), .y(nor_s));
  nand8 u_nand (.a(a), .b(b), .y(nand_s));
  xnor8 u_xnor (.a(a), .b(b), .y(xnor_s));
  not8  u_not  (.a(a), .y(not_s));

  // Select the gate output addressed by op.
  always_comb begin
    y = a;
    case (op)
      OP_AND:  y = and_s;
      OP_OR:   y = or_s;
      OP_XOR:  y = xor_s;
      OP_NOR:  y = nor_s;
      OP_NAND: y = nand_s;
      OP_XNOR: y = xnor_s;
      OP_NOT:  y = not_s;
      OP_PASS: y = a;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/nand8.sv
// 8-bit bitwise NAND gate of the logic gate array.
module nand8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = ~(a & b);
endmodule

// File: rtl/nor8.sv
// 8-bit bitwise NOR gate of the logic gate array.
module nor8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = ~(a | b);
endmodule

// File: rtl/not8.sv
// 8-bit bitwise inverter of the logic gate array.
module not8 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = ~a;
endmodule

// File: rtl/or8.sv
// 8-bit bitwise OR gate of the logic gate array.
module or8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = a | b;
endmodule

// File: rtl/xnor8.sv
// 8-bit bitwise XNOR gate of the logic gate array.
module xnor8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = ~(a ^ b);
endmodule

// File: rtl/xor8.sv
// 8-bit bitwise XOR gate of the logic gate array.
module xor8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);
  assign y = a ^ b;
endmodule

// File: rtl/logic_op_sequencer.sv
// Collects opcode/operand beats, drives the 8-bit gate array and holds the registered result and flags.
// Define LOGIC_PARITY_FLAG_EN to generate the even-parity flag on out_p (otherwise it is tied to 0).
module logic_op_sequencer
  import logic_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_z,
  output logic             out_n,
  output logic             out_p
);

  state_e           state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [OPW-1:0]   op_r;
  logic [WIDTH-1:0] out_data_r;
  logic             z_r;
  logic             n_r;
  logic [WIDTH-1:0] result_s;

  logic8_select u_select (
    .a  (a_r),
    .b  (b_r),
    .op (op_r),
    .y  (result_s)
  );

  // Handshake flags decode the state only, so in_ready never depends on out_ready.
  assign in_ready  = ~rst & ((state_r == ST_IDLE) | (state_r == ST_LOAD_B));
  assign out_valid = ~rst & (state_r == ST_DONE);
  assign out_data  = out_data_r;
  assign out_z     = z_r;
  assign out_n     = n_r;

  // Sequencer FSM with operand capture and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      op_r       <= {OPW{1'b0}};
      out_data_r <= {WIDTH{1'b0}};
      z_r        <= 1'b0;
      n_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            a_r     <= in_data;
            op_r    <= in_op;
            state_r <= is_unary(in_op) ? ST_EXEC : ST_LOAD_B;
          end
        end
        ST_LOAD_B: begin
          if (in_valid) begin
            b_r     <= in_data;
            state_r <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          out_data_r <= result_s;
          z_r        <= (result_s == {WIDTH{1'b0}});
          n_r        <= result_s[WIDTH-1];
          state_r    <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

`ifdef LOGIC_PARITY_FLAG_EN
  logic p_r;

  // Parity flag tracks the same value loaded into out_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_r <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      p_r <= parity_even(result_s);
    end else begin
      p_r <= p_r;
    end
  end

  assign out_p = p_r;
`else
  assign out_p = 1'b0;
`endif

endmodule
